sr_input_cond: RTL and testbench
================================

SR_INPUT_COND -- requirements
Module: sr_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive equal synchronized samples required to accept a level change; legal range 2..65535.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port set_btn  input  1  SHALL be the raw asynchronous set pushbutton, active-high.
REQ-005 Port rst_btn  input  1  SHALL be the raw asynchronous reset pushbutton, active-high.
REQ-006 Port s  output  1  SHALL be the one-cycle set command pulse to the downstream SR flip-flop.
REQ-007 Port r  output  1  SHALL be the one-cycle reset command pulse to the downstream SR flip-flop.
REQ-008 Port set_lvl  output  1  SHALL be the debounced level of set_btn.
REQ-009 Port rst_lvl  output  1  SHALL be the debounced level of rst_btn.
REQ-010 Port conflict  output  1  SHALL flag a suppressed simultaneous set/reset command (see Configuration).

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer; only the second-stage output (sync) SHALL feed the logic.
REQ-012 Each channel SHALL run an independent FSM with states IDLE (stable low), CHK_HI, PRESSED (stable high), CHK_LO, plus a counter of width ceil(log2(DEBOUNCE_CYCLES))+1.
REQ-013 IDLE: sync=1 -> CHK_HI, cnt<=1; else remain.
REQ-014 CHK_HI: sync=0 -> IDLE, cnt<=0; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt<=0; else cnt<=cnt+1.
REQ-015 PRESSED: sync=0 -> CHK_LO, cnt<=1; else remain.
REQ-016 CHK_LO: sync=1 -> PRESSED, cnt<=0; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt<=0; else cnt<=cnt+1.
REQ-017 set_lvl/rst_lvl SHALL be registered, 1 in PRESSED and CHK_LO, 0 in IDLE and CHK_HI.
REQ-018 A channel's command pulse SHALL be registered high for exactly one cycle, on the edge at which the channel enters PRESSED; no pulse SHALL be generated on release.
REQ-019 Latency: with a raw input held high from before rising edge 1, the pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+2.
REQ-020 Any glitch (sync toggles) during CHK_HI/CHK_LO SHALL abort the check per REQ-014/016, with no pulse and no level change.
REQ-021 s and r SHALL never be high in the same cycle; resolution of simultaneous entry into PRESSED is per REQ-025/026.
REQ-022 A held button SHALL produce exactly one pulse regardless of hold time.

Reset
REQ-023 While rst=1 at a rising edge: both FSMs -> IDLE, counters and synchronizer flops -> 0, s=r=set_lvl=rst_lvl=conflict=0.
REQ-024 Reset asserted mid-debounce or mid-pulse SHALL abort it; a button still held after reset release SHALL be re-debounced from IDLE and produce one pulse.

Configuration
REQ-025 Macro SRIN_CONFLICT_EN defined: when both channels enter PRESSED on the same edge, s and r SHALL stay 0 and conflict SHALL be high for that one cycle.
REQ-026 SRIN_CONFLICT_EN undefined: simultaneous entry SHALL yield r=1, s=0 (reset wins); conflict SHALL be tied 0.

Verification
REQ-027 DEBOUNCE_CYCLES=4, set_btn 0->1 held before edge 1 -> s=1 only in the cycle after edge 6, set_lvl=1 from then, r=0 throughout.
REQ-028 DEBOUNCE_CYCLES=4, set_btn high 3 cycles then low 1 cycle, repeated 5 times -> s never asserts, set_lvl stays 0.
REQ-029 set_btn held 100 cycles then released -> exactly one s pulse; set_lvl falls the cycle after the 4th consecutive low sync sample; no pulse on release.
REQ-030 set_btn and rst_btn rise on the same cycle, DEBOUNCE_CYCLES=4 -> with SRIN_CONFLICT_EN: s=r=0, conflict=1 for one cycle; without: r=1, s=0, conflict=0.
REQ-031 rst pulsed 1 cycle while CHK_HI cnt=2, set_btn kept high -> all outputs 0 during reset; s pulses once, the cycle after the (4+2)th edge counted from the first edge after reset release.

Source files
------------

// File: rtl/sr_input_cond.sv
// Pushbutton conditioner for an SR latch: sync, debounce, one-shot pulses.
// Define SRIN_CONFLICT_EN to suppress simultaneous commands and flag conflict.
module sr_input_ch #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic lvl,
  output logic hit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CHK_HI,
    PRESSED,
    CHK_LO
  } state_t;

  logic [1:0]    sy;
  logic          sync;
  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;

  assign sync = sy[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sy  <= '0;
      st  <= IDLE;
      cnt <= '0;
      lvl <= 1'b0;
    end else begin
      sy  <= {sy[0], btn};
      st  <= st_n;
      cnt <= cnt_n;
      lvl <= (st_n == PRESSED) || (st_n == CHK_LO);
    end
  end

  // hit marks a completed press; a glitch back from CHK_LO is not a press
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    hit   = 1'b0;
    unique case (st)
      IDLE: begin
        if (sync) begin
          st_n  = CHK_HI;
          cnt_n = ONE;
        end
      end
      CHK_HI: begin
        if (!sync) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else if (cnt == LAST) begin
          st_n  = PRESSED;
          cnt_n = '0;
          hit   = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!sync) begin
          st_n  = CHK_LO;
          cnt_n = ONE;
        end
      end
      CHK_LO: begin
        if (sync) begin
          st_n  = PRESSED;
          cnt_n = '0;
        end else if (cnt == LAST) begin
          st_n  = IDLE;
          cnt_n = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        st_n  = IDLE;
        cnt_n = '0;
      end
    endcase
  end

endmodule

module sr_input_cond #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic set_btn,
  input  logic rst_btn,
  output logic s,
  output logic r,
  output logic set_lvl,
  output logic rst_lvl,
  output logic conflict
);

  logic set_hit;
  logic rst_hit;
  logic s_n;
  logic r_n;
  logic c_n;

  sr_input_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_set (
    .clk(clk),
    .rst(rst),
    .btn(set_btn),
    .lvl(set_lvl),
    .hit(set_hit)
  );

  sr_input_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_rst (
    .clk(clk),
    .rst(rst),
    .btn(rst_btn),
    .lvl(rst_lvl),
    .hit(rst_hit)
  );

`ifdef SRIN_CONFLICT_EN
  assign s_n = set_hit & ~rst_hit;
  assign r_n = rst_hit & ~set_hit;
  assign c_n = set_hit & rst_hit;
`else
  // reset command wins a tie
  assign s_n = set_hit & ~rst_hit;
  assign r_n = rst_hit;
  assign c_n = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s        <= 1'b0;
      r        <= 1'b0;
      conflict <= 1'b0;
    end else begin
      s        <= s_n;
      r        <= r_n;
      conflict <= c_n;
    end
  end

endmodule

// File: tb/tb_sr_input_cond.sv
// Directed bench for sr_input_cond with a scoreboard of expected pulses.
// Expected pulse cycles are pushed when a button is driven.
module tb_sr_input_cond;

  localparam int DC = 4;
  localparam logic [2:0] EV_S = 3'b001;
  localparam logic [2:0] EV_R = 3'b010;
  localparam logic [2:0] EV_C = 3'b100;

  logic clk = 1'b0;
  logic rst;
  logic set_btn;
  logic rst_btn;
  logic s;
  logic r;
  logic set_lvl;
  logic rst_lvl;
  logic conflict;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  ev_t sb[$];
  int  edges = 0;
  int  checks = 0;
  int  failures = 0;

  sr_input_cond #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_btn(set_btn),
    .rst_btn(rst_btn),
    .s(s),
    .r(r),
    .set_lvl(set_lvl),
    .rst_lvl(rst_lvl),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(int cyc, logic [2:0] kind);
    ev_t e;
    e.cyc  = cyc;
    e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic step();
    logic [2:0] obs;
    ev_t e;
    @(posedge clk);
    #1;
    edges++;
    obs = {conflict, r, s};
    chk("s_r_excl", int'(s & r), 0);
    if (obs != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", int'(obs), 0);
      end else begin
        e = sb.pop_front();
        chk("evt_cycle", edges, e.cyc);
        chk("evt_kind", int'(obs), int'(e.kind));
      end
    end else if (sb.size() != 0 && sb[0].cyc < edges) begin
      e = sb.pop_front();
      chk("missed_evt", int'(obs), int'(e.kind));
    end
  endtask

  initial begin
    int n;
    int m;
    logic [2:0] tie_kind;
    rst     = 1'b1;
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (3) step();
    chk("reset_outs", int'({s, r, set_lvl, rst_lvl, conflict}), 0);
    rst = 1'b0;
    repeat (2) step();

    // long hold: one pulse, level follows, no pulse on release
    set_btn = 1'b1;
    n = edges;
    push(n + DC + 2, EV_S);
    repeat (100) begin
      step();
      chk("set_lvl_hold", int'(set_lvl), int'(edges >= n + DC + 2));
      chk("rst_lvl_idle", int'(rst_lvl), 0);
    end
    set_btn = 1'b0;
    m = edges;
    repeat (10) begin
      step();
      chk("set_lvl_rel", int'(set_lvl), int'(edges < m + DC + 2));
    end

    // short glitchy presses never qualify
    repeat (5) begin
      set_btn = 1'b1;
      repeat (3) begin
        step();
        chk("glitch_lvl", int'(set_lvl), 0);
      end
      set_btn = 1'b0;
      step();
      chk("glitch_lvl", int'(set_lvl), 0);
    end
    repeat (6) step();

    // simultaneous press
`ifdef SRIN_CONFLICT_EN
    tie_kind = EV_C;
`else
    tie_kind = EV_R;
`endif
    set_btn = 1'b1;
    rst_btn = 1'b1;
    n = edges;
    push(n + DC + 2, tie_kind);
    repeat (12) begin
      step();
      chk("tie_set_lvl", int'(set_lvl), int'(edges >= n + DC + 2));
      chk("tie_rst_lvl", int'(rst_lvl), int'(edges >= n + DC + 2));
    end
    set_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (10) step();
    chk("tie_lvl_rel", int'({set_lvl, rst_lvl}), 0);

    // reset mid-debounce, button held: re-debounce from scratch
    set_btn = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_outs", int'({s, r, set_lvl, rst_lvl, conflict}), 0);
    rst = 1'b0;
    n = edges;
    push(n + DC + 2, EV_S);
    repeat (30) begin
      step();
      chk("midrst_lvl", int'(set_lvl), int'(edges >= n + DC + 2));
    end
    set_btn = 1'b0;
    repeat (10) step();

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
